// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one FIFO write port between NUM_REQ producers.
// It keeps a conservative occupancy count so that issued writes can never overrun the FIFO.
module fifo_write_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          Sync_Reset,
  input  logic [NUM_REQ-1:0]            req_vec,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_vec,
  input  logic                          rd_pop,
  output logic [NUM_REQ-1:0]            ack_vec,
  output logic                          Wr_enable,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [ADDR_WIDTH:0]           level,
  output logic                          full_flg_out,
  output logic                          empty_flg_out
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LEVEL_W = ADDR_WIDTH + 1;

  // Handshake: a producer raises req_vec[i] with stable data and holds both until
  // ack_vec[i] pulses for one cycle; in that ack cycle it may drop req or present
  // its next word, which is sampled no earlier than the following edge.

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   scan_sel;
  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic               space;
  logic               grant;
  int                 scan_idx;

  // Scanning backwards lets the last hit win, which is the first eligible
  // producer at or after rr_ptr in round-robin order.
  always_comb begin
    eligible  = req_vec & ~ack_vec;
    space     = (level < LEVEL_W'(DEPTH)) | rd_pop;
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    scan_sel  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
      scan_sel = PTR_W'(scan_idx);
      if (eligible[scan_sel]) begin
        found     = 1'b1;
        grant_idx = scan_sel;
      end
    end
    grant = found & space;
  end

  always_ff @(posedge clk) begin
    if (Sync_Reset) begin
      Wr_enable <= 1'b0;
      data_in   <= '0;
      ack_vec   <= '0;
      rr_ptr    <= '0;
      level     <= '0;
    end else begin
      Wr_enable <= grant;
      if (grant) begin
        data_in <= data_vec[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        ack_vec <= NUM_REQ'(1) << grant_idx;
        rr_ptr  <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end else begin
        ack_vec <= '0;
      end
      // A pop on an empty count with nothing issued is a protocol error; hold at zero.
      case ({grant, rd_pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= (level == '0) ? '0 : level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign full_flg_out  = (level == LEVEL_W'(DEPTH));
  assign empty_flg_out = (level == '0);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: grant order, latency, level accounting,
// full stall, simultaneous grant and pop, and reset in mid-operation.
module tb_fifo_write_arbiter;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int NR = 4;

  logic             clk;
  logic             Sync_Reset;
  logic [NR-1:0]    req_vec;
  logic [NR*DW-1:0] data_vec;
  logic             rd_pop;
  logic [NR-1:0]    ack_vec;
  logic             Wr_enable;
  logic [DW-1:0]    data_in;
  logic [AW:0]      level;
  logic             full_flg_out;
  logic             empty_flg_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  fifo_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk           (clk),
    .Sync_Reset    (Sync_Reset),
    .req_vec       (req_vec),
    .data_vec      (data_vec),
    .rd_pop        (rd_pop),
    .ack_vec       (ack_vec),
    .Wr_enable     (Wr_enable),
    .data_in       (data_in),
    .level         (level),
    .full_flg_out  (full_flg_out),
    .empty_flg_out (empty_flg_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] val);
    data_vec[idx*DW +: DW] = val;
  endtask

  task automatic expect_state(input string tag, input logic wr, input logic [NR-1:0] ack,
                              input logic [AW:0] lvl);
    check({tag, "_wr"},  32'(Wr_enable), 32'(wr));
    check({tag, "_ack"}, 32'(ack_vec),   32'(ack));
    check({tag, "_lvl"}, 32'(level),     32'(lvl));
  endtask

  // scoreboard: every issued write must match the next expected word
  always @(posedge clk) begin
    #1;
    if (Wr_enable) begin
      if (exp_q.size() == 0) check("wr_unexpected", 32'(data_in), 32'hFFFF_FFFF);
      else                   check("wr_data", 32'(data_in), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    logic [NR-1:0] req_exp;

    Sync_Reset = 1'b1;
    req_vec    = '0;
    data_vec   = '0;
    rd_pop     = 1'b0;
    tick();
    tick();
    Sync_Reset = 1'b0;
    check("rst_wr",    32'(Wr_enable),     32'd0);
    check("rst_ack",   32'(ack_vec),       32'd0);
    check("rst_lvl",   32'(level),         32'd0);
    check("rst_empty", 32'(empty_flg_out), 32'd1);
    check("rst_full",  32'(full_flg_out),  32'd0);
    check("rst_data",  32'(data_in),       32'd0);
    tick();
    expect_state("idle", 1'b0, 4'b0000, 3'd0);

    // single producer, held request: writes two cycles apart
    req_vec = 4'b0001;
    set_data(0, 8'd5);
    exp_q.push_back(8'd5);
    tick();
    expect_state("single1", 1'b1, 4'b0001, 3'd1);
    set_data(0, 8'd8);
    exp_q.push_back(8'd8);
    tick();
    expect_state("single_gap", 1'b0, 4'b0000, 3'd1);
    tick();
    expect_state("single2", 1'b1, 4'b0001, 3'd2);
    req_vec = '0;
    tick();
    expect_state("single_done", 1'b0, 4'b0000, 3'd2);
    rd_pop = 1'b1;
    tick();
    tick();
    rd_pop = 1'b0;
    check("drain_lvl",   32'(level),         32'd0);
    check("drain_empty", 32'(empty_flg_out), 32'd1);

    Sync_Reset = 1'b1;
    tick();
    Sync_Reset = 1'b0;

    // round-robin, one write per cycle, pops once level hits 2
    req_vec = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      set_data(i, 8'(10 + i));
      exp_q.push_back(8'(10 + i));
    end
    req_exp = 4'b1111;
    for (int k = 0; k < NR; k++) begin
      tick();
      expect_state($sformatf("rr%0d", k), 1'b1, 4'(1 << k), (k == 0) ? 3'd1 : 3'd2);
      req_exp = req_exp & ~4'(1 << k);
      req_vec = req_exp;
      rd_pop  = (k >= 1);
    end
    tick();
    expect_state("rr_drain1", 1'b0, 4'b0000, 3'd1);
    tick();
    expect_state("rr_drain0", 1'b0, 4'b0000, 3'd0);
    rd_pop = 1'b0;

    // fill to DEPTH, then a fifth word stalls until a pop frees room
    req_vec = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      set_data(i, 8'(20 + i));
      exp_q.push_back(8'(20 + i));
    end
    req_exp = 4'b1111;
    for (int k = 0; k < NR; k++) begin
      tick();
      expect_state($sformatf("fill%0d", k), 1'b1, 4'(1 << k), 3'(k + 1));
      req_exp = req_exp & ~4'(1 << k);
      req_vec = req_exp;
    end
    check("full_flag", 32'(full_flg_out), 32'd1);
    req_vec = 4'b0001;
    set_data(0, 8'd24);
    exp_q.push_back(8'd24);
    tick();
    expect_state("stall1", 1'b0, 4'b0000, 3'd4);
    tick();
    expect_state("stall2", 1'b0, 4'b0000, 3'd4);
    rd_pop = 1'b1;
    tick();
    expect_state("full_pop_grant", 1'b1, 4'b0001, 3'd4);
    rd_pop  = 1'b0;
    req_vec = '0;
    tick();
    expect_state("full_idle", 1'b0, 4'b0000, 3'd4);

    // simultaneous grant and pop at level 2
    rd_pop = 1'b1;
    tick();
    tick();
    req_vec = 4'b0010;
    set_data(1, 8'd30);
    exp_q.push_back(8'd30);
    tick();
    expect_state("grant_pop", 1'b1, 4'b0010, 3'd2);
    rd_pop  = 1'b0;
    req_vec = '0;
    tick();
    expect_state("grant_pop_after", 1'b0, 4'b0000, 3'd2);

    // reset on an edge that would grant at level 3
    req_vec = 4'b0100;
    set_data(2, 8'd40);
    exp_q.push_back(8'd40);
    tick();
    expect_state("pre_rst", 1'b1, 4'b0100, 3'd3);
    req_vec = '0;
    tick();
    req_vec = 4'b1010;
    set_data(1, 8'd51);
    set_data(3, 8'd50);
    Sync_Reset = 1'b1;
    tick();
    expect_state("mid_rst", 1'b0, 4'b0000, 3'd0);
    check("mid_rst_empty", 32'(empty_flg_out), 32'd1);
    Sync_Reset = 1'b0;
    exp_q.push_back(8'd51);
    exp_q.push_back(8'd50);
    tick();
    expect_state("post_rst1", 1'b1, 4'b0010, 3'd1);
    req_vec = 4'b1000;
    tick();
    expect_state("post_rst2", 1'b1, 4'b1000, 3'd2);
    req_vec = '0;

    // pops past zero saturate
    rd_pop = 1'b1;
    tick();
    tick();
    tick();
    expect_state("sat_zero", 1'b0, 4'b0000, 3'd0);
    rd_pop = 1'b0;
    tick();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin write arbiter sitting in front of the FIFO's write port on the write clock domain.
- Shares the single FIFO write port (`Wr_enable` / `data_in`) between NUM_REQ producers and grants at most one write per cycle.
- Keeps its own conservative occupancy count, driven by write grants and read-pop notifications, so the FIFO is never overrun.
- Returns a one-cycle acknowledge pulse to the producer whose word was issued.

Parameters:
- ADDR_WIDTH, 2, FIFO address width; FIFO depth DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, FIFO word width.
- NUM_REQ, 4, number of producers (2..8).

Ports:
- clk  input  1  write-side clock; all logic on rising edge.
- Sync_Reset  input  1  synchronous, active-high reset, sampled on rising clk.
- req_vec  input  NUM_REQ  per-producer write request; held until acked.
- data_vec  input  NUM_REQ*DATA_WIDTH  producer words; producer i uses bits [i*DATA_WIDTH +: DATA_WIDTH]; held stable while req high.
- rd_pop  input  1  one-cycle pulse per word actually read from the FIFO, already in the clk domain.
- ack_vec  output  NUM_REQ  registered one-hot pulse: the producer's word was issued this cycle.
- Wr_enable  output  1  registered FIFO write enable.
- data_in  output  DATA_WIDTH  registered FIFO write data.
- level  output  ADDR_WIDTH+1  current occupancy count, 0..DEPTH.
- full_flg_out  output  1  asserted when level == DEPTH.
- empty_flg_out  output  1  asserted when level == 0.

Behaviour:
- Reset (synchronous):
  - At a rising edge with Sync_Reset=1: Wr_enable=0, data_in=0, ack_vec=0, rr_ptr=0, level=0.
  - Resulting flags: full_flg_out=0, empty_flg_out=1.
  - Reset overrides any grant or rd_pop at that same edge; a word being issued is dropped and not acked.
- Eligible producers: eligible[i] = req_vec[i] & ~ack_vec[i].
  - A producer acked in the current cycle is masked, so a held request is never written twice.
  - Consequence: one producer can write at most every 2nd cycle; multiple producers together can reach 1 write per cycle.
- Space check:
  - space = (level < DEPTH) | rd_pop.
  - A grant is made only when space=1 and at least one producer is eligible.
- Grant selection:
  - Granted producer g = first eligible index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - This is combinational, with registered effect at the next edge.
- On a grant edge:
  - Wr_enable<=1.
  - data_in<=data_vec[g].
  - ack_vec<=one-hot(g).
  - rr_ptr<=(g+1) mod NUM_REQ.
- On a no-grant edge:
  - Wr_enable<=0, ack_vec<=0.
  - data_in holds its value.
  - rr_ptr holds its value.
- Latency: request sampled at edge N → Wr_enable and ack high for cycle N..N+1 → FIFO writes at edge N+1.
- Level update (each edge):
  - level <= level + grant − rd_pop.
  - Grant and pop at the same edge leave level unchanged.
  - rd_pop while level==0 and no grant is a protocol error; level saturates at 0.
- Accounting: level counts issued writes in advance, so it is conservative (≥ true FIFO occupancy). The FIFO full condition is therefore never reached by a write the arbiter issued.
- Boundary conditions:
  - At level==DEPTH with rd_pop=0: no grant; requests stall with req held and ack low; rr_ptr is not advanced.
  - At level==DEPTH with rd_pop=1: a grant is allowed and level stays at DEPTH.
  - Wrap: rr_ptr wraps from NUM_REQ−1 to 0. A single requester with all others idle is granted every 2nd cycle.
- Producer rule: a producer may drop req, or present its next word with req still high, in the cycle its ack is high. Its new data is sampled no earlier than the following edge.
- Flags are combinational from level only.

Test Plan:
- Reset then idle: hold Sync_Reset for 2 cycles, req_vec=0 → Wr_enable=0, ack_vec=0, level=0, empty_flg_out=1, full_flg_out=0.
- Single producer: req_vec=4'b0001, data 8'd5 → next cycle Wr_enable=1, data_in=5, ack_vec=0001, level=1. Holding req with new data 8'd8 → second write exactly 2 cycles after the first.
- Round-robin: all 4 request with data 10,11,12,13 and rd_pop pulsed each cycle after level reaches 2 → write order 10,11,12,13, one per cycle, rr_ptr back to 0.
- Full stall: 4 producers, no rd_pop → exactly 4 writes, level=4, full_flg_out=1. A 5th request waits with ack low; one rd_pop pulse → that request is granted next edge and level stays 4.
- Simultaneous grant and pop at level=2 → level remains 2, write issued.
- Reset mid-operation: assert Sync_Reset on an edge where a grant would occur with level=3 → no Wr_enable, no ack, level=0, rr_ptr=0; after release the same request is granted first.
